// File: rtl/alu_mc.sv
//------------------------------------------------------------------------------
// alu_mc : multi-cycle ALU with valid/ready handshake on both sides.
//          Logic/add/sub/shift/compare ops finish in one cycle; mul/mulhu/divu/
//          remu run WIDTH iteration cycles (shift-add / restoring division).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrlSig,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluOut,
  output logic             carry,
  output logic             zero
);

  localparam int c_SHW = $clog2(WIDTH);
  localparam logic [c_SHW-1:0] c_LAST = c_SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_b, r_hi, r_lo;
  logic [c_SHW-1:0]   r_cnt;

  logic               w_iter;
  logic [c_SHW-1:0]   w_sh;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;

  logic [WIDTH:0]     w_mul_sum, w_div_sh;
  logic [WIDTH-1:0]   w_div_sub;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_nhi, w_nlo, w_fres;
  logic               w_fc;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign w_iter    = ctrlSig[3] & ctrlSig[2];
  assign w_sh      = op2[c_SHW-1:0];
  assign w_sum     = {1'b0, op1} + {1'b0, op2};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    case (ctrlSig)
      4'b0000: w_res = ~op1;
      4'b0001: w_res = op1 & op2;
      4'b0010: w_res = op1 | op2;
      4'b0011: w_res = op1 ^ op2;
      4'b0100: begin w_res = w_sum[WIDTH-1:0]; w_c = w_sum[WIDTH]; end
      4'b0101: begin w_res = op1 - op2; w_c = (op1 < op2); end
      4'b0110: w_res = op1 >> w_sh;
      4'b0111: w_res = op1 << w_sh;
      4'b1000: begin w_res = op1 - op2; w_c = (op1 > op2); end
      4'b1001: w_res = WIDTH'($signed(op1) >>> w_sh);
      4'b1010: w_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      4'b1011: w_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      default: ;
    endcase
  end

  // One iteration step: r_hi holds product-high / remainder, r_lo holds
  // multiplier-being-consumed / quotient-being-built.
  always_comb begin
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_div_sh  = {r_hi, r_lo[WIDTH-1]};
    w_div_ge  = (w_div_sh >= {1'b0, r_b});
    w_div_sub = w_div_sh[WIDTH-1:0] - r_b;
    if (!r_op[1]) begin
      w_nhi = w_mul_sum[WIDTH:1];
      w_nlo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end else begin
      w_nhi = w_div_ge ? w_div_sub : w_div_sh[WIDTH-1:0];
      w_nlo = {r_lo[WIDTH-2:0], w_div_ge};
    end
    w_fres = r_op[0] ? w_nhi : w_nlo;
    w_fc   = r_op[1] ? (r_b == '0) : (|w_nhi);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = w_iter ? S_ITER : S_DONE;
      S_ITER:  if (r_cnt == c_LAST) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      aluOut  <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_iter) begin
              r_op  <= ctrlSig[1:0];
              r_b   <= op2;
              r_lo  <= op1;
              r_hi  <= '0;
              r_cnt <= '0;
            end else begin
              aluOut <= w_res;
              carry  <= w_c;
              zero   <= (w_res == '0);
            end
          end
        end
        S_ITER: begin
          r_hi  <= w_nhi;
          r_lo  <= w_nlo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            aluOut <= w_fres;
            carry  <= w_fc;
            zero   <= (w_fres == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
